// File: rtl/filter_pkg.sv
// Shared defaults, output-register state encoding and the round/saturate helper
// used by every channel lane of the convolution MAC.
package filter_pkg;

   localparam int PIX_W_DEF   = 8;
   localparam int COEFF_W_DEF = 24;
   localparam int FRAC_W_DEF  = 10;
   localparam int NUM_CH_DEF  = 3;
   localparam int SUM_W       = 64;
   localparam int MAX_PIX_W   = 16;

   typedef logic [NUM_CH_DEF*PIX_W_DEF-1:0] pix_bus_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   typedef struct packed {
      logic                 sat;
      logic [MAX_PIX_W-1:0] pix;
   } sat_pix_t;

   // Round half-up, drop the fraction bits, then clip to [0, 2^pix_w - 1].
   function automatic sat_pix_t sat_round(input logic signed [SUM_W-1:0] sum,
                                          input int frac_w,
                                          input int pix_w);
      logic signed [SUM_W-1:0] v_half;
      logic signed [SUM_W-1:0] v_r;
      logic signed [SUM_W-1:0] v_max;
      sat_pix_t                v_res;
      v_half = 64'sd1 <<< (frac_w - 1);
      v_r    = (sum + v_half) >>> frac_w;
      v_max  = (64'sd1 <<< pix_w) - 64'sd1;
      v_res  = '0;
      if (v_r < 64'sd0) begin
         v_res.sat = 1'b1;
         v_res.pix = '0;
      end else if (v_r > v_max) begin
         v_res.sat = 1'b1;
         v_res.pix = v_max[MAX_PIX_W-1:0];
      end else begin
         v_res.sat = 1'b0;
         v_res.pix = v_r[MAX_PIX_W-1:0];
      end
      return v_res;
   endfunction

endpackage

// File: rtl/filter_mac_lane.sv
// One colour channel: pixel x coefficient product, tap accumulator and the
// normalised, saturated output register.
module filter_mac_lane
   import filter_pkg::*;
#(
   parameter int PIX_W   = PIX_W_DEF,
   parameter int COEFF_W = COEFF_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF,
   parameter int ACC_W   = 40
) (
   input  logic                      clk,
   input  logic                      nreset,
   input  logic                      i_clr,
   input  logic                      i_acc,
   input  logic                      i_fin,
   input  logic [PIX_W-1:0]          i_pix,
   input  logic signed [COEFF_W-1:0] i_coeff,
   output logic [PIX_W-1:0]          o_pix,
   output logic                      o_sat
);

   localparam int PROD_W = PIX_W + 1 + COEFF_W;

   logic signed [PIX_W:0]     w_pix_s;
   logic signed [PROD_W-1:0]  w_prod;
   logic signed [ACC_W-1:0]   w_prod_ext;
   logic signed [ACC_W-1:0]   w_sum;
   logic signed [SUM_W-1:0]   w_sum_wide;
   sat_pix_t                  w_norm;
   logic                      w_unused_hi;
   logic signed [ACC_W-1:0]   r_acc;
   logic [PIX_W-1:0]          r_pix;
   logic                      r_sat;

   assign w_pix_s     = {1'b0, i_pix};
   assign w_prod      = PROD_W'(w_pix_s) * PROD_W'(i_coeff);
   assign w_prod_ext  = ACC_W'(w_prod);
   assign w_sum       = r_acc + w_prod_ext;
   assign w_sum_wide  = SUM_W'(w_sum);
   assign w_norm      = sat_round(w_sum_wide, FRAC_W, PIX_W);
   assign w_unused_hi = |w_norm.pix;

   // Accumulate non-final taps; the final tap loads the result and restarts the sum.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_acc <= '0;
         r_pix <= '0;
         r_sat <= 1'b0;
      end else if (i_clr) begin
         r_acc <= '0;
      end else if (i_fin) begin
         r_acc <= '0;
         r_pix <= w_norm.pix[PIX_W-1:0];
         r_sat <= w_norm.sat;
      end else if (i_acc) begin
         r_acc <= w_sum;
      end else begin
         r_acc <= r_acc;
      end
   end

   assign o_pix = r_pix;
   assign o_sat = r_sat;

endmodule

// File: rtl/filter_conv_mac_nch.sv
// Multi-channel convolution MAC: owns the tap counter, the input/output
// handshake and the output-register occupancy; channel math lives in the lanes.
module filter_conv_mac_nch
   import filter_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int PIX_W   = PIX_W_DEF,
   parameter int COEFF_W = COEFF_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF,
   parameter int TAPS    = 9,
   parameter int ACC_W   = 40
) (
   input  logic                      clk,
   input  logic                      nreset,
   input  logic                      flush,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [NUM_CH*PIX_W-1:0]   s_pix,
   input  logic signed [COEFF_W-1:0] s_coeff,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [NUM_CH*PIX_W-1:0]   m_pix,
   output logic [NUM_CH-1:0]         m_sat
);

   localparam int              TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

   out_state_e       r_state;
   out_state_e       w_state_nxt;
   logic [TAP_W-1:0] r_tap_cnt;
   logic [TAP_W-1:0] w_tap_nxt;
   logic             w_s_ready;
   logic             w_accept;
   logic             w_final;
   logic             w_acc;

   // A stalled output blocks every input beat, not just the final tap.
   assign w_s_ready = nreset && !flush && ((r_state == OUT_EMPTY) || m_ready);
   assign w_accept  = s_valid && w_s_ready;
   assign w_final   = w_accept && (r_tap_cnt == LAST_TAP);
   assign w_acc     = w_accept && !w_final;

   // Next tap count and output-register occupancy.
   always_comb begin
      w_state_nxt = r_state;
      w_tap_nxt   = r_tap_cnt;
      if (flush) begin
         w_tap_nxt = '0;
      end else if (w_final) begin
         w_tap_nxt = '0;
      end else if (w_accept) begin
         w_tap_nxt = r_tap_cnt + TAP_W'(1);
      end else begin
         w_tap_nxt = r_tap_cnt;
      end
      case (r_state)
         OUT_EMPTY: begin
            if (w_final) begin
               w_state_nxt = OUT_FULL;
            end else begin
               w_state_nxt = OUT_EMPTY;
            end
         end
         OUT_FULL: begin
            if (w_final) begin
               w_state_nxt = OUT_FULL;
            end else if (m_ready) begin
               w_state_nxt = OUT_EMPTY;
            end else begin
               w_state_nxt = OUT_FULL;
            end
         end
         default: w_state_nxt = OUT_EMPTY;
      endcase
   end

   // State and tap-counter registers.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state   <= OUT_EMPTY;
         r_tap_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_tap_cnt <= w_tap_nxt;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      filter_mac_lane #(
         .PIX_W   (PIX_W),
         .COEFF_W (COEFF_W),
         .FRAC_W  (FRAC_W),
         .ACC_W   (ACC_W)
      ) u_lane (
         .clk     (clk),
         .nreset  (nreset),
         .i_clr   (flush),
         .i_acc   (w_acc),
         .i_fin   (w_final),
         .i_pix   (s_pix[c*PIX_W +: PIX_W]),
         .i_coeff (s_coeff),
         .o_pix   (m_pix[c*PIX_W +: PIX_W]),
         .o_sat   (m_sat[c])
      );
   end

   assign s_ready = w_s_ready;
   assign m_valid = (r_state == OUT_FULL);

endmodule
